// File: rtl/rng_request_scheduler_if.sv
// Seed and requester handshake bundle for rng_request_scheduler.
// master drives seeds and requests; slave is the scheduler.
interface rng_request_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic               seed_valid;
    logic [31:0]        seed;
    logic               seed_ready;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [31:0]        rnd_data;
    logic               reseed_req;
    logic               health_err;

    modport master (
        output seed_valid, seed, req,
        input  seed_ready, gnt, rnd_data, reseed_req, health_err
    );

    modport slave (
        input  seed_valid, seed, req,
        output seed_ready, gnt, rnd_data, reseed_req, health_err
    );
endinterface

// File: rtl/rng_request_scheduler.sv
// 32-bit LFSR source with seed life cycle, health check and
// round-robin word delivery to NUM_REQ requesters.
module rng_request_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int WARMUP_CYCLES   = 16,
    parameter int RESEED_INTERVAL = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rng_request_scheduler_if.slave  bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int CW = $clog2(RESEED_INTERVAL + 1);

    localparam logic [2:0] S_UNSEEDED = 3'd0;
    localparam logic [2:0] S_WARMUP   = 3'd1;
    localparam logic [2:0] S_SERVE    = 3'd2;
    localparam logic [2:0] S_RESEED   = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;

    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(RESEED_INTERVAL - 1);

    logic [2:0]         state;
    logic [31:0]        lfsr;
    logic [31:0]        lfsr_next;
    logic [31:0]        rnd_q;
    logic [WW-1:0]      warm_cnt;
    logic [CW-1:0]      word_cnt;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_any;
    logic [NUM_REQ-1:0] gnt_q;
    logic               reseed_q;
    logic               health_q;
    logic               seed_ready;
    logic               accept;
    logic               zero_next;
    logic               repeat_word;

    assign lfsr_next = {lfsr[30:0],
                        lfsr[31] ^ lfsr[28] ^ lfsr[25] ^ lfsr[24]};

    assign seed_ready  = (state != S_WARMUP);
    assign accept      = bus.seed_valid & seed_ready & (bus.seed != '0);
    assign zero_next   = (lfsr_next == '0);
    // rnd_q always holds the last granted word
    assign repeat_word = (lfsr_next == rnd_q);

    always_comb begin
        int          sum;
        logic [PW-1:0] idx;
        sum      = 0;
        idx      = '0;
        pick_any = 1'b0;
        pick_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = (int'(rr_ptr) + i) % NUM_REQ;
            idx = PW'(sum);
            if (!pick_any && bus.req[idx]) begin
                pick_any = 1'b1;
                pick_idx = idx;
            end
        end
        pick_oh = pick_any ? (NUM_REQ'(1) << pick_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_UNSEEDED;
            lfsr     <= '0;
            warm_cnt <= '0;
            word_cnt <= '0;
            rr_ptr   <= PW'(NUM_REQ - 1);
            gnt_q    <= '0;
            rnd_q    <= '0;
            reseed_q <= 1'b0;
            health_q <= 1'b0;
        end else begin
            gnt_q <= '0;
            if (accept) begin
                // a voluntary reseed in SERVE pre-empts any grant
                lfsr     <= bus.seed;
                warm_cnt <= '0;
                word_cnt <= '0;
                reseed_q <= 1'b0;
                health_q <= 1'b0;
                state    <= S_WARMUP;
            end else begin
                case (state)
                    S_WARMUP: begin
                        if (zero_next) begin
                            health_q <= 1'b1;
                            state    <= S_FAULT;
                        end else begin
                            lfsr <= lfsr_next;
                            if (warm_cnt == WARM_LAST)
                                state <= S_SERVE;
                            else
                                warm_cnt <= warm_cnt + 1'b1;
                        end
                    end
                    S_SERVE: begin
                        if (zero_next || (pick_any && repeat_word)) begin
                            health_q <= 1'b1;
                            state    <= S_FAULT;
                        end else if (pick_any) begin
                            lfsr     <= lfsr_next;
                            gnt_q    <= pick_oh;
                            rnd_q    <= lfsr_next;
                            rr_ptr   <= pick_idx;
                            word_cnt <= word_cnt + 1'b1;
                            if (word_cnt == WORD_LAST) begin
                                reseed_q <= 1'b1;
                                state    <= S_RESEED;
                            end
                        end
                    end
                    S_UNSEEDED, S_RESEED, S_FAULT: begin
                        state <= state;
                    end
                    default: state <= S_UNSEEDED;
                endcase
            end
        end
    end

    assign bus.seed_ready = seed_ready;
    assign bus.gnt        = gnt_q;
    assign bus.rnd_data   = rnd_q;
    assign bus.reseed_req = reseed_q;
    assign bus.health_err = health_q;
endmodule

// File: tb/tb_rng_request_scheduler.sv
// Directed bench for rng_request_scheduler (NUM_REQ=4,
// WARMUP_CYCLES=16, RESEED_INTERVAL=8).
module tb_rng_request_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rng_request_scheduler_if #(.NUM_REQ(4)) bus ();

    rng_request_scheduler #(
        .NUM_REQ(4),
        .WARMUP_CYCLES(16),
        .RESEED_INTERVAL(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    function automatic logic [31:0] step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[28] ^ x[25] ^ x[24]};
    endfunction

    function automatic logic [31:0] stepn(input logic [31:0] x, input int n);
        logic [31:0] v;
        v = x;
        for (int i = 0; i < n; i++) v = step(v);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.seed_valid = 1'b0;
        bus.seed       = '0;
        bus.req        = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load_seed(input logic [31:0] s);
        bus.seed_valid = 1'b1;
        bus.seed       = s;
        tick();
        bus.seed_valid = 1'b0;
        bus.seed       = '0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.gnt, bus.reseed_req, bus.health_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.gnt, bus.reseed_req, bus.health_err});
        end
        vectors++;
        if (bus.rnd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rnd: got %h want 0", bus.rnd_data);
        end
        vectors++;
        if (bus.seed_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_seed_ready: got %b want 1", bus.seed_ready);
        end
    endtask

    task automatic test_first_word();
        logic [31:0] m;
        int idle_bad;
        do_reset();
        bus.req = 4'b0001;
        load_seed(32'h1);
        vectors++;
        if (bus.seed_ready !== 1'b0) begin
            errors++;
            $display("FAIL warmup_seed_ready: got %b want 0", bus.seed_ready);
        end
        idle_bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.gnt !== 4'b0) idle_bad++;
        end
        vectors++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL warmup_idle: got %0d grants want 0", idle_bad);
        end
        tick();
        m = stepn(32'h1, 17);
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.rnd_data !== m) begin
            errors++;
            $display("FAIL first_word: got %b/%h want 0001/%h",
                     bus.gnt, bus.rnd_data, m);
        end
        bus.req = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g [5];
        logic [31:0] m;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        load_seed(32'h1);
        repeat (16) tick();
        m = stepn(32'h1, 16);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            m = step(m);
            vectors++;
            if (bus.gnt !== exp_g[i] || bus.rnd_data !== m) begin
                errors++;
                $display("FAIL rr_%0d: got %b/%h want %b/%h",
                         i, bus.gnt, bus.rnd_data, exp_g[i], m);
            end
        end
        bus.req = 4'b0;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0 || bus.rnd_data !== m) begin
            errors++;
            $display("FAIL rr_idle: got %b/%h want 0000/%h",
                     bus.gnt, bus.rnd_data, m);
        end
        bus.req = 4'b0100;
        tick();
        m = step(m);
        vectors++;
        if (bus.gnt !== 4'b0100 || bus.rnd_data !== m) begin
            errors++;
            $display("FAIL rr_single: got %b/%h want 0100/%h",
                     bus.gnt, bus.rnd_data, m);
        end
        bus.req = 4'b0;
    endtask

    task automatic test_reseed();
        logic [31:0] m;
        int grants;
        int idle_bad;
        do_reset();
        load_seed(32'h1);
        repeat (16) tick();
        bus.req = 4'b1111;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.gnt !== 4'b0) grants++;
        end
        vectors++;
        if (grants != 8 || bus.reseed_req !== 1'b1) begin
            errors++;
            $display("FAIL reseed_count: got %0d grants req=%b want 8 req=1",
                     grants, bus.reseed_req);
        end
        tick();
        vectors++;
        if (bus.gnt !== 4'b0 || bus.reseed_req !== 1'b1) begin
            errors++;
            $display("FAIL reseed_wait: got %b req=%b want 0000 req=1",
                     bus.gnt, bus.reseed_req);
        end
        load_seed(32'hDEADBEEF);
        vectors++;
        if (bus.reseed_req !== 1'b0) begin
            errors++;
            $display("FAIL reseed_clear: got %b want 0", bus.reseed_req);
        end
        idle_bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.gnt !== 4'b0) idle_bad++;
        end
        tick();
        m = stepn(32'hDEADBEEF, 17);
        vectors++;
        if (idle_bad != 0 || bus.gnt !== 4'b0001 || bus.rnd_data !== m) begin
            errors++;
            $display("FAIL reseed_resume: got idle=%0d %b/%h want 0 0001/%h",
                     idle_bad, bus.gnt, bus.rnd_data, m);
        end
        bus.req = 4'b0;
    endtask

    task automatic test_zero_seed();
        logic [31:0] m;
        int bad;
        do_reset();
        bus.req        = 4'b1111;
        bus.seed_valid = 1'b1;
        bus.seed       = 32'h0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.gnt !== 4'b0 || bus.health_err !== 1'b0 ||
                bus.seed_ready !== 1'b1) bad++;
        end
        bus.seed_valid = 1'b0;
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_seed: got %0d bad cycles want 0", bad);
        end
        load_seed(32'h1);
        repeat (16) tick();
        tick();
        m = stepn(32'h1, 17);
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.rnd_data !== m) begin
            errors++;
            $display("FAIL zero_seed_then_seed: got %b/%h want 0001/%h",
                     bus.gnt, bus.rnd_data, m);
        end
        bus.req = 4'b0;
    endtask

    task automatic test_health();
        logic [31:0] m;
        do_reset();
        load_seed(32'h1);
        repeat (16) tick();
        bus.req = 4'b1111;
        force dut.lfsr = 32'h0;
        tick();
        release dut.lfsr;
        vectors++;
        if (bus.health_err !== 1'b1 || bus.gnt !== 4'b0) begin
            errors++;
            $display("FAIL health_trip: got err=%b gnt=%b want 1/0000",
                     bus.health_err, bus.gnt);
        end
        tick();
        vectors++;
        if (bus.health_err !== 1'b1 || bus.gnt !== 4'b0 ||
            bus.seed_ready !== 1'b1) begin
            errors++;
            $display("FAIL health_sticky: got err=%b gnt=%b rdy=%b want 1/0000/1",
                     bus.health_err, bus.gnt, bus.seed_ready);
        end
        load_seed(32'h12345678);
        vectors++;
        if (bus.health_err !== 1'b0 || bus.seed_ready !== 1'b0) begin
            errors++;
            $display("FAIL health_clear: got err=%b rdy=%b want 0/0",
                     bus.health_err, bus.seed_ready);
        end
        repeat (16) tick();
        tick();
        m = stepn(32'h12345678, 17);
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.rnd_data !== m) begin
            errors++;
            $display("FAIL health_resume: got %b/%h want 0001/%h",
                     bus.gnt, bus.rnd_data, m);
        end
        bus.req = 4'b0;
    endtask

    task automatic test_async_reset();
        int bad;
        do_reset();
        load_seed(32'h1);
        repeat (16) tick();
        bus.req = 4'b1111;
        tick();
        tick();
        vectors++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL pre_reset_gnt: got %b want 0010", bus.gnt);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.gnt !== 4'b0 || bus.rnd_data !== 32'h0 ||
            bus.reseed_req !== 1'b0 || bus.health_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %b/%h/%b/%b want 0000/0/0/0",
                     bus.gnt, bus.rnd_data, bus.reseed_req, bus.health_err);
        end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.gnt !== 4'b0 || bus.seed_ready !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_unseeded: got %0d bad cycles want 0", bad);
        end
        bus.req = 4'b0;
    endtask

    initial begin
        bus.seed_valid = 1'b0;
        bus.seed       = '0;
        bus.req        = '0;
        test_reset();
        test_first_word();
        test_round_robin();
        test_reseed();
        test_zero_seed();
        test_health();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
